// File: rtl/alien_renderer.sv
// alien_renderer: redraws the alien sprite whenever the movement FSM reports a
// new top-left position. A redraw is one erase pass over the last drawn
// position followed by one draw pass at the new position, one pixel per clock.
// The erase pass is skipped when nothing has been drawn yet.
//
// Ports
//   clk     in   1  system clock
//   resetn  in   1  synchronous active-low reset
//   pos_x   in   8  alien top-left x
//   pos_y   in   7  alien top-left y
//   busy    out  1  high while an erase or draw pass is running
//   plot    out  1  pixel write strobe to the VGA adapter
//   vga_x   out  8  pixel x
//   vga_y   out  7  pixel y
//   colour  out  3  pixel colour
//
// busy/plot/vga_x/vga_y/colour are a combinational decode of the scan state so
// that the first plot appears on the cycle right after the change is sampled.
module alien_renderer #(
    parameter int unsigned SPR_W     = 8,
    parameter int unsigned SPR_H     = 4,
    parameter logic [2:0]  FG_COLOUR = 3'b010,
    parameter logic [2:0]  BG_COLOUR = 3'b000,
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    // Row 0 in the top byte; within a row the MSB is column 0.
    parameter logic [SPR_W*SPR_H-1:0] SPRITE = 32'h3C7E_DBA5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] pos_x,
    input  logic [6:0] pos_y,
    output logic       busy,
    output logic       plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour
);

    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int unsigned PIX_W = ((SPR_W * SPR_H) > 1) ? $clog2(SPR_W * SPR_H) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPR_H - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(SPR_W * SPR_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [X_W-1:0]   old_x_q, old_x_d;
    logic [Y_W-1:0]   old_y_q, old_y_d;
    logic [X_W-1:0]   new_x_q, new_x_d;
    logic [Y_W-1:0]   new_y_q, new_y_d;
    logic             drawn_valid_q, drawn_valid_d;

    logic             change_c;
    logic             last_pix_c;
    logic             scan_c;
    logic [X_W-1:0]   base_x_c;
    logic [Y_W-1:0]   base_y_c;
    logic [X_W:0]     sum_x_c;
    logic [Y_W:0]     sum_y_c;
    logic [PIX_W-1:0] pix_idx_c;
    logic             sprite_bit_c;

    // A redraw is needed when nothing is on screen yet or the position moved.
    assign change_c   = !drawn_valid_q || (pos_x != old_x_q) || (pos_y != old_y_q);
    assign last_pix_c = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // State and scan registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            old_x_q       <= '0;
            old_y_q       <= '0;
            new_x_q       <= '0;
            new_y_q       <= '0;
            drawn_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            old_x_q       <= old_x_d;
            old_y_q       <= old_y_d;
            new_x_q       <= new_x_d;
            new_y_q       <= new_y_d;
            drawn_valid_q <= drawn_valid_d;
        end
    end

    // Next-state logic: raster scan, erase-then-draw sequencing.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        old_x_d       = old_x_q;
        old_y_d       = old_y_q;
        new_x_d       = new_x_q;
        new_y_d       = new_y_q;
        drawn_valid_d = drawn_valid_q;

        case (state_q)
            S_IDLE: begin
                if (change_c) begin
                    new_x_d = pos_x;
                    new_y_d = pos_y;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = drawn_valid_q ? S_ERASE : S_DRAW;
                end
            end

            S_ERASE: begin
                if (last_pix_c) begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_DRAW;
                end else if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end

            S_DRAW: begin
                if (last_pix_c) begin
                    // Sprite is now fully on screen at new_x/new_y.
                    old_x_d       = new_x_q;
                    old_y_d       = new_y_q;
                    drawn_valid_d = 1'b1;
                    col_d         = '0;
                    row_d         = '0;
                    state_d       = S_IDLE;
                end else if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pixel decode. Sums are one bit wider so off-screen pixels are detected
    // before truncation to the adapter's coordinate width.
    assign scan_c   = (state_q == S_ERASE) || (state_q == S_DRAW);
    assign base_x_c = (state_q == S_ERASE) ? old_x_q : new_x_q;
    assign base_y_c = (state_q == S_ERASE) ? old_y_q : new_y_q;
    assign sum_x_c  = {1'b0, base_x_c} + (X_W + 1)'(col_q);
    assign sum_y_c  = {1'b0, base_y_c} + (Y_W + 1)'(row_q);

    assign pix_idx_c    = PIX_W'(row_q) * PIX_W'(SPR_W) + PIX_W'(col_q);
    assign sprite_bit_c = SPRITE[PIX_LAST - pix_idx_c];

    always_comb begin
        busy   = scan_c;
        plot   = 1'b0;
        vga_x  = '0;
        vga_y  = '0;
        colour = BG_COLOUR;
        if (scan_c) begin
            plot  = (sum_x_c < (X_W + 1)'(SCREEN_W)) && (sum_y_c < (Y_W + 1)'(SCREEN_H));
            vga_x = sum_x_c[X_W-1:0];
            vga_y = sum_y_c[Y_W-1:0];
            if ((state_q == S_DRAW) && sprite_bit_c) begin
                colour = FG_COLOUR;
            end
        end
    end

endmodule

// File: tb/tb_alien_renderer.sv
module tb_alien_renderer;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic       busy;
    logic       plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;

    always #5 clk = ~clk;

    alien_renderer dut (
        .clk    (clk),
        .resetn (resetn),
        .pos_x  (pos_x),
        .pos_y  (pos_y),
        .busy   (busy),
        .plot   (plot),
        .vga_x  (vga_x),
        .vga_y  (vga_y),
        .colour (colour)
    );

    localparam logic [2:0] FG = 3'b010;
    localparam logic [2:0] BG = 3'b000;

    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    int   n_cmp = 0;
    int   n_err = 0;
    pix_t exp_q[$];
    int   rows [4] = '{'h3C, 'h7E, 'hDB, 'hA5};

    int         plot_cnt = 0;
    int         busy_cnt = 0;
    logic [2:0] screen [256][128];

    // Expected pixel stream for one pass over the 8x4 sprite at (bx,by).
    task automatic push_pass(input int bx, input int by, input bit draw);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                int   x;
                int   y;
                pix_t p;
                x      = bx + c;
                y      = by + r;
                p.plot = (x < 160) && (y < 120);
                p.x    = 8'(x);
                p.y    = 7'(y);
                p.c    = (draw && (((rows[r] >> (7 - c)) & 1) == 1)) ? FG : BG;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!busy && n < 20) begin
            step(1);
            n++;
        end
        n_cmp++;
        if (!busy) begin
            n_err++;
            $display("FAIL %s: busy never rose within 20 cycles", name);
        end
    endtask

    // Reference model: a queue of the pixels a redraw must emit; when empty
    // the renderer is idle and compares the position against the last drawn one.
    bit   m_valid = 1'b0;
    int   m_ox = 0;
    int   m_oy = 0;

    initial begin
        logic [19:0] exp_v;
        logic [19:0] act_v;
        bit          was_idle;
        pix_t        p;
        @(posedge clk);
        forever begin
            @(negedge clk);
            was_idle = (exp_q.size() == 0);
            if (was_idle) begin
                exp_v = 20'h0;
            end else begin
                p     = exp_q.pop_front();
                exp_v = {1'b1, p};
            end
            act_v = {busy, plot, vga_x, vga_y, colour};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL cycle @%0t {busy,plot,x,y,colour}: got %h expected %h",
                         $time, act_v, exp_v);
            end
            if (!resetn) begin
                exp_q.delete();
                m_valid = 1'b0;
            end else if (was_idle && (!m_valid || int'(pos_x) != m_ox || int'(pos_y) != m_oy)) begin
                if (m_valid) push_pass(m_ox, m_oy, 1'b0);
                push_pass(int'(pos_x), int'(pos_y), 1'b1);
                m_ox    = int'(pos_x);
                m_oy    = int'(pos_y);
                m_valid = 1'b1;
            end
        end
    end

    // Observed pixel writes and activity counters.
    always @(negedge clk) begin
        if (plot === 1'b1) begin
            plot_cnt++;
            screen[vga_x][vga_y] = colour;
        end
        if (busy === 1'b1) busy_cnt++;
    end

    initial begin
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 128; j++)
                screen[i][j] = 3'b111;

        // T1: reset, then first draw at (2,15) with no erase
        resetn = 1'b0;
        pos_x  = 8'd2;
        pos_y  = 7'd15;
        step(2);
        @(negedge clk);
        check("reset_plot",   int'(plot),   0);
        check("reset_busy",   int'(busy),   0);
        check("reset_vga_x",  int'(vga_x),  0);
        check("reset_vga_y",  int'(vga_y),  0);
        check("reset_colour", int'(colour), int'(BG));
        step(1);
        resetn   = 1'b1;
        plot_cnt = 0;
        busy_cnt = 0;
        step(40);
        check("t1_plots", plot_cnt, 32);
        check("t1_busy",  busy_cnt, 32);
        check("t1_px_4_15_fg", int'(screen[4][15]), int'(FG));
        check("t1_px_2_15_bg", int'(screen[2][15]), int'(BG));
        check("t1_px_9_18_fg", int'(screen[9][18]), int'(FG));

        // T2: move to (3,15): erase + draw
        plot_cnt = 0;
        busy_cnt = 0;
        pos_x    = 8'd3;
        step(70);
        check("t2_plots", plot_cnt, 64);
        check("t2_busy",  busy_cnt, 64);
        check("t2_px_2_15_erased", int'(screen[2][15]), int'(BG));
        check("t2_px_5_15_fg",     int'(screen[5][15]), int'(FG));
        check("t2_px_10_17_fg",    int'(screen[10][17]), int'(FG));

        // T3: move to (4,15), then to (5,15) on the 10th busy cycle
        plot_cnt = 0;
        busy_cnt = 0;
        pos_x    = 8'd4;
        step(1);
        wait_busy("t3_start");
        step(9);
        pos_x = 8'd5;
        step(140);
        check("t3_busy",  busy_cnt, 128);
        check("t3_plots", plot_cnt, 128);
        check("t3_px_7_15_fg",  int'(screen[7][15]),  int'(FG));
        check("t3_px_6_15_bg",  int'(screen[6][15]),  int'(BG));
        check("t3_px_11_16_fg", int'(screen[11][16]), int'(FG));

        // T4: clipped draw at (155,118) from reset
        resetn = 1'b0;
        pos_x  = 8'd155;
        pos_y  = 7'd118;
        step(2);
        resetn   = 1'b1;
        plot_cnt = 0;
        busy_cnt = 0;
        step(40);
        check("t4_plots", plot_cnt, 10);
        check("t4_busy",  busy_cnt, 32);

        // T5: reset on the 20th cycle of an erase
        pos_x = 8'd20;
        pos_y = 7'd30;
        step(1);
        wait_busy("t5_start");
        step(19);
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_abort_plot", int'(plot), 0);
        check("t5_abort_busy", int'(busy), 0);
        step(1);
        resetn   = 1'b1;
        plot_cnt = 0;
        busy_cnt = 0;
        step(40);
        check("t5_redraw_busy",  busy_cnt, 32);
        check("t5_redraw_plots", plot_cnt, 32);
        check("t5_px_22_30_fg",  int'(screen[22][30]), int'(FG));

        // T6: steady position, no activity
        plot_cnt = 0;
        busy_cnt = 0;
        step(200);
        check("t6_plots", plot_cnt, 0);
        check("t6_busy",  busy_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
